orb_frame_reader: RTL
=====================

// Module: orb_frame_reader
// PURPOSE
//  Read side of the orbital frame RAM that fullPacker fills. On a frame strobe, reads FRAME_WORDS
//  words sequentially from address 0. Presents each word on a valid/ready stream to the downstream
//  line transmitter. Sits between the frame RAM read port and the serializer.
// PARAMETERS
//  ADDR_W       11    RAM address width (matches packer wAddr)
//  DATA_W       12    word width (matches packer orbWord)
//  FRAME_WORDS  2048  words per frame, 1..2**ADDR_W
//  RD_LAT       2     RAM read latency in clk cycles, 1..4 (altsyncram with q register = 2)
// PORTS
//  clk        in   1       clock
//  rst        in   1       async reset, active-low
//  start      in   1       frame strobe, 1-cycle pulse from frame timing
//  rd_addr    out  ADDR_W  RAM read address
//  rd_q       in   DATA_W  RAM read data, valid RD_LAT cycles after rd_addr
//  out_word   out  DATA_W  stream data
//  out_valid  out  1       stream valid
//  out_ready  in   1       stream ready from transmitter
//  busy       out  1       frame read in progress
//  frame_done out  1       1-cycle pulse after last word accepted
//  ovr        out  1       sticky: start arrived while busy
//  clr_we     out  1       clear-write enable (ORB_CLR_EN only)
//  clr_addr   out  ADDR_W  clear-write address (ORB_CLR_EN only)
// BEHAVIOUR
//  - Reset (rst=0, any time incl. mid-frame): state IDLE; rd_addr, out_word, clr_addr = 0;
//    out_valid, busy, frame_done, ovr, clr_we = 0. No frame_done for an aborted frame.
//  - FSM states: IDLE, FETCH, HOLD.
//    IDLE : start=1 -> FETCH, rd_addr=0, busy=1.
//    FETCH: wait RD_LAT cycles (latency counter), then out_word<=rd_q, out_valid=1 -> HOLD.
//    HOLD : out_valid & out_ready = transfer. On transfer, out_valid=0.
//           If rd_addr==FRAME_WORDS-1: frame_done=1 for 1 cycle, busy=0 -> IDLE.
//           Else: rd_addr+1 -> FETCH.
//  - First word: out_valid rises RD_LAT+1 cycles after the start edge.
//    Word period: >= RD_LAT+2 cycles per word.
//  - out_word remains stable while out_valid=1 and out_ready=0 (no drop, no change).
//  - start while busy (FETCH/HOLD): ignored, ovr<=1 (sticky until reset). Frame continues.
//  - start in the same cycle as the final transfer: ignored, ovr=1. The FSM returns to IDLE.
//  - rd_addr is unsigned and never wraps past FRAME_WORDS-1. Overflow of the ADDR_W counter is unreachable.
//  - out_ready is ignored outside HOLD.
// CONFIGURATION
//  ORB_CLR_EN defined:
//    - On each transfer, clr_we=1 for exactly 1 cycle, with clr_addr = rd_addr of the transferred word.
//    - The RAM write mux zeroes that location, so slow-channel slots not refreshed next frame read 0.
//    - The mux gives clr_we priority below packer WE.
//  ORB_CLR_EN undefined: clr_we tied 0, clr_addr tied 0. RAM contents persist across frames.
// STRUCTURE
//  - Package orb_pkg: ORB_ADDR_W=11, ORB_DATA_W=12 constants and the reader state encoding
//    (IDLE=0, FETCH=1, HOLD=2). Shared with the packer and the transmitter.
//  - Sub-module orb_lat_cnt: loadable down-counter that signals "q valid" after RD_LAT cycles.
//    It is reused by other RAM readers.
// TESTING
//  1. Preload RAM[i]=i. Pulse start, out_ready=1 -> 2048 words 0..2047 in order.
//     First out_valid at cycle 3 (RD_LAT=2); one frame_done after the last word; busy low after.
//  2. out_ready=0 for 10 cycles while word 5 is held -> out_word=5 stays stable, out_valid stays 1.
//     Word 6 follows only after the transfer.
//  3. Second start pulse at word 100 -> ovr=1, frame still ends at word 2047, a single frame_done.
//  4. rst low at word 300, then start -> all outputs 0 during reset.
//     New frame restarts at rd_addr=0, no frame_done from the aborted frame.
//  5. ORB_CLR_EN, FRAME_WORDS=32 -> 32 clr_we pulses, clr_addr 0..31, each coincident with a transfer.
//     A second frame reads all zeros.
//  6. Without ORB_CLR_EN, same as 5 -> clr_we never 1; second frame repeats the first frame's data.

Source files
------------

// File: rtl/orb_pkg.sv
// Shared constants and the frame-reader state encoding for the orbital frame
// path (packer, reader, transmitter).
//   ORB_ADDR_W     : frame RAM address width
//   ORB_DATA_W     : frame RAM word width
//   orb_rd_state_t : reader FSM encoding (IDLE=0, FETCH=1, HOLD=2)
package orb_pkg;

  localparam int ORB_ADDR_W = 11;
  localparam int ORB_DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } orb_rd_state_t;

endpackage

// File: rtl/orb_lat_cnt.sv
// Loadable down-counter that covers a synchronous RAM read latency.
// Load it in the cycle the read address is presented. "done" then goes high
// in the cycle in which the RAM read data for that address is valid.
//   clk  : clock
//   rst  : async reset, active-low
//   load : restart the count at LAT
//   done : count has expired (also high while idle)
module orb_lat_cnt
  import orb_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int CW = $clog2(LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/orb_frame_reader.sv
// Read side of the orbital frame RAM. A start strobe reads FRAME_WORDS words
// from address 0 upward and presents them one at a time on a valid/ready
// stream towards the line transmitter.
//
// Optional feature: define ORB_CLR_EN to emit a clear-write for every word
// that is handed downstream, so that slots not refreshed by the packer read
// back as zero in the next frame. Without it, clr_we/clr_addr are tied to 0.
//
// Ports:
//   clk, rst   : clock, async active-low reset
//   start      : 1-cycle frame strobe
//   rd_addr    : RAM read address
//   rd_q       : RAM read data, valid RD_LAT cycles after rd_addr
//   out_word   : stream data
//   out_valid  : stream valid
//   out_ready  : stream ready
//   busy       : frame read in progress
//   frame_done : 1-cycle pulse after the last word of a frame is accepted
//   ovr        : sticky, start arrived while a frame was being read
//   clr_we     : clear-write enable (zero when ORB_CLR_EN is undefined)
//   clr_addr   : clear-write address (zero when ORB_CLR_EN is undefined)
//   state      : reader FSM state, for observation
//
// Stream handshake: a word transfers on every rising clk edge where
// out_valid and out_ready are both 1. Once out_valid is raised, out_valid and
// out_word hold steady until that transfer. out_ready is ignored outside HOLD.
module orb_frame_reader
  import orb_pkg::*;
#(
  parameter int ADDR_W      = ORB_ADDR_W,
  parameter int DATA_W      = ORB_DATA_W,
  parameter int FRAME_WORDS = 2048,
  parameter int RD_LAT      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_q,
  output logic [DATA_W-1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              ovr,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output orb_rd_state_t     state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  orb_rd_state_t state_next;
  logic          lat_load;
  logic          q_valid;
  logic          xfer;
  logic          last;

  assign xfer = (state == HOLD) && out_valid && out_ready;
  assign last = (rd_addr == LAST_ADDR);

  // The counter is reloaded each time a new address goes out, so FETCH
  // lasts RD_LAT+1 cycles and the capture lines up with the RAM's q.
  orb_lat_cnt #(
    .LAT (RD_LAT)
  ) u_lat_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (lat_load),
    .done (q_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    lat_load   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          lat_load   = 1'b1;
        end
      end
      FETCH: begin
        if (q_valid) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (xfer) begin
          if (last) begin
            state_next = IDLE;
          end else begin
            state_next = FETCH;
            lat_load   = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr    <= '0;
      out_word   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // A strobe during any non-idle cycle is dropped, including the cycle
      // of the final transfer; the running frame is never restarted.
      if (start && (state != IDLE)) begin
        ovr <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            rd_addr <= '0;
            busy    <= 1'b1;
          end
        end
        FETCH: begin
          if (q_valid) begin
            out_word  <= rd_q;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (xfer) begin
            out_valid <= 1'b0;
            if (last) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ORB_CLR_EN
  // Clear-write issued in the transfer cycle itself; rd_addr still points at
  // the word being handed over. The RAM write mux ranks this below packer WE.
  assign clr_we   = xfer;
  assign clr_addr = xfer ? rd_addr : '0;
`else
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

endmodule
